// File: rtl/cse_x25_axi_pkg.sv
// Shared definitions for the cse_x25 AXI-Lite master: FSM state codes and
// AXI response encodings, plus a small response-classification helper.
package cse_x25_axi_pkg;

  // Master FSM state codes
  localparam logic [2:0] e_idle    = 3'd0;
  localparam logic [2:0] e_wr_req  = 3'd1;
  localparam logic [2:0] e_wr_resp = 3'd2;
  localparam logic [2:0] e_rd_addr = 3'd3;
  localparam logic [2:0] e_rd_data = 3'd4;
  localparam logic [2:0] e_resp    = 3'd5;

  // AXI BRESP/RRESP encodings
  localparam logic [1:0] e_axi_resp_okay   = 2'b00;
  localparam logic [1:0] e_axi_resp_exokay = 2'b01;
  localparam logic [1:0] e_axi_resp_slverr = 2'b10;
  localparam logic [1:0] e_axi_resp_decerr = 2'b11;

  // Any response other than OKAY is reported to the requester as an error
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != e_axi_resp_okay);
  endfunction

endpackage

// File: rtl/cse_x25_axilite_master.sv
// Single-outstanding AXI-Lite master. Accepts one command on a valid/ready
// interface, runs the matching AXI-Lite write or read, and returns the read
// data and error flag on a valid/ready response interface.
module cse_x25_axilite_master
  import cse_x25_axi_pkg::*;
#(
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_we_i,
  input  logic [axi_addr_width_p-1:0] cmd_addr_i,
  input  logic [axi_data_width_p-1:0] cmd_wdata_i,

  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic                        resp_we_o,
  output logic [axi_data_width_p-1:0] resp_rdata_o,
  output logic                        resp_err_o,

  output logic [axi_addr_width_p-1:0] axi_awaddr_o,
  output logic                        axi_awvalid_o,
  input  logic                        axi_awready_i,

  output logic [axi_data_width_p-1:0] axi_wdata_o,
  output logic                        axi_wvalid_o,
  input  logic                        axi_wready_i,

  input  logic [1:0]                  axi_bresp_i,
  input  logic                        axi_bvalid_i,
  output logic                        axi_bready_o,

  output logic [axi_addr_width_p-1:0] axi_araddr_o,
  output logic                        axi_arvalid_o,
  input  logic                        axi_arready_i,

  input  logic [axi_data_width_p-1:0] axi_rdata_i,
  input  logic [1:0]                  axi_rresp_i,
  input  logic                        axi_rvalid_i,
  output logic                        axi_rready_o
);

  // Byte-lane offset bits inside one data word; forced to zero on capture
  localparam int addr_lsb_lp = $clog2(axi_data_width_p / 8);
  localparam logic [axi_addr_width_p-1:0] addr_mask_lp =
    {{(axi_addr_width_p - addr_lsb_lp){1'b1}}, {addr_lsb_lp{1'b0}}};

  logic [2:0]                  state_r;
  logic                        we_r;
  logic [axi_addr_width_p-1:0] addr_r;
  logic [axi_data_width_p-1:0] wdata_r;
  logic [axi_data_width_p-1:0] rdata_r;
  logic                        err_r;
  logic                        aw_done_r;
  logic                        w_done_r;

  logic                        aw_hs_s;
  logic                        w_hs_s;
  logic                        aw_done_next_s;
  logic                        w_done_next_s;

  // Handshake and valid/ready decode from registered state; reset_i masks
  // every valid/ready so nothing is offered while the block is held in reset
  always_comb begin
    cmd_ready_o    = (state_r == e_idle)    & ~reset_i;
    resp_valid_o   = (state_r == e_resp)    & ~reset_i;
    axi_awvalid_o  = (state_r == e_wr_req)  & ~aw_done_r & ~reset_i;
    axi_wvalid_o   = (state_r == e_wr_req)  & ~w_done_r  & ~reset_i;
    axi_bready_o   = (state_r == e_wr_resp) & ~reset_i;
    axi_arvalid_o  = (state_r == e_rd_addr) & ~reset_i;
    axi_rready_o   = (state_r == e_rd_data) & ~reset_i;
    aw_hs_s        = axi_awvalid_o & axi_awready_i;
    w_hs_s         = axi_wvalid_o  & axi_wready_i;
    aw_done_next_s = aw_done_r | aw_hs_s;
    w_done_next_s  = w_done_r  | w_hs_s;
  end

  // Address/data/response outputs come straight from capture registers
  always_comb begin
    axi_awaddr_o = addr_r;
    axi_araddr_o = addr_r;
    axi_wdata_o  = wdata_r;
    resp_we_o    = we_r;
    resp_rdata_o = rdata_r;
    resp_err_o   = err_r;
  end

  // Transaction FSM with command capture and response capture
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      err_r     <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (state_r)
        e_idle: begin
          if (cmd_valid_i) begin
            we_r    <= cmd_we_i;
            addr_r  <= cmd_addr_i & addr_mask_lp;
            wdata_r <= cmd_wdata_i;
            state_r <= cmd_we_i ? e_wr_req : e_rd_addr;
          end
        end
        e_wr_req: begin
          // AW and W complete independently; leave once both have, counting
          // any handshake happening on this very edge
          aw_done_r <= aw_done_next_s;
          w_done_r  <= w_done_next_s;
          if (aw_done_next_s && w_done_next_s) begin
            state_r <= e_wr_resp;
          end
        end
        e_wr_resp: begin
          if (axi_bvalid_i) begin
            err_r     <= resp_is_err(axi_bresp_i);
            rdata_r   <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            state_r   <= e_resp;
          end
        end
        e_rd_addr: begin
          if (axi_arready_i) begin
            state_r <= e_rd_data;
          end
        end
        e_rd_data: begin
          if (axi_rvalid_i) begin
            rdata_r <= axi_rdata_i;
            err_r   <= resp_is_err(axi_rresp_i);
            state_r <= e_resp;
          end
        end
        e_resp: begin
          if (resp_ready_i) begin
            state_r <= e_idle;
          end
        end
        default: begin
          state_r   <= e_idle;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
